gfifo_src_arb: RTL
==================

Name: gfifo_src_arb

Overview:
- Upstream feeder for the output GFIFO stage.
- Merges NUM_SRC callback/message sources into a single registered beat stream on the GF request bus (request, cbid, length, 512-bit data).
- Grants whole messages round-robin and never interleaves beats of different messages.
- Honours the GF full backpressure and reports a busy flag plus a running message count.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DW, 512, data beat width; matches the GF data bus.
- CBW, 20, callback-id width.
- LW, 12, message length field width in beats; a value of 0 encodes 2^LW beats.

Ports:
- fclk  in  1  fast clock; all logic is on this single clock.
- resetN  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source beat valid.
- src_ready  out  NUM_SRC  per-source beat accept; one-hot or zero.
- src_cbid  in  NUM_SRC*CBW  per-source callback id; sampled at grant.
- src_len  in  NUM_SRC*LW  per-source message length; sampled at grant.
- src_data  in  NUM_SRC*DW  per-source beat data.
- gf_req  out  1  output beat valid.
- gf_sop  out  1  first beat of a message.
- gf_eop  out  1  last beat of a message.
- gf_cbid  out  CBW  cbid of the current message; stable for the whole message.
- gf_len  out  LW  length of the current message; stable for the whole message.
- gf_idata  out  DW  beat data.
- gf_full  in  1  downstream full; an output beat is consumed on a cycle with gf_req=1 and gf_full=0.
- gf_busy  out  1  asserted while a message is granted or output beats remain.
- msg_count  out  32  number of messages whose eop beat was consumed; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release). All of the following clear to 0:
  - gf_req, gf_sop, gf_eop, gf_cbid, gf_len, gf_idata, src_ready, gf_busy, msg_count
  - round-robin pointer, remaining counter
  - FSM returns to IDLE.
  - Reset mid-message discards the message; no partial output appears after release.
- FSM IDLE:
  - src_ready=0.
  - If any src_valid is set, grant the first set bit at or after rr_ptr (wrapping).
  - Latch g, src_cbid[g] and src_len[g] into cbid_r and len_r.
  - Load remaining = (len==0) ? 2^LW : len, using an LW+1-bit counter.
  - Go to XFER.
- FSM XFER:
  - load = !gf_req || !gf_full.
  - src_ready[g] = load; all other ready bits are 0.
  - Source beat accepted when src_valid[g] && src_ready[g]. On acceptance, on the next edge:
    - gf_req=1, gf_idata=src_data[g]
    - gf_sop=1 if this is the first beat
    - gf_eop=1 if remaining==1
    - gf_cbid=cbid_r, gf_len=len_r
    - remaining decrements.
  - load with no source beat: gf_req goes 0 (bubble).
  - When the eop beat is accepted from the source, go to IDLE and set rr_ptr=(g+1) mod NUM_SRC.
  - Sources must keep src_valid asserted until the message completes. A gap in src_valid only inserts bubbles; there is no timeout.
- Output register:
  - While gf_req=1 and gf_full=1, every gf_* output holds unchanged.
  - No beat is ever dropped or duplicated.
- Latency:
  - src_valid rising in IDLE to first gf_req: 2 cycles (1 arbitration, 1 register).
  - Steady state, with gf_full=0 and src_valid held: 1 beat per cycle.
  - 1 bubble cycle between consecutive messages, caused by the IDLE arbitration cycle.
- The IDLE arbitration for the next message may overlap a final output beat that is still stalled by gf_full. The next message's first beat loads only when load permits.
- gf_busy = (state==XFER) || gf_req.
- msg_count increments on the cycle the eop output beat is consumed (gf_req && gf_eop && !gf_full).
- Simultaneous events:
  - The eop source beat and a new src_valid on another source in the same cycle: the new request is served in the following IDLE cycle.
  - Changes on src_len or src_cbid after grant are ignored.

Test Plan:
- Single source 0, len=3, gf_full=0 → gf_req high for 3 consecutive cycles starting 2 cycles after src_valid. sop on beat 1, eop on beat 3, gf_len=3, cbid echoed, msg_count=1.
- All 4 sources valid, len=1 each, rr_ptr=0 → grant order 0,1,2,3. Output beats spaced 2 cycles apart. msg_count=4. Re-raising source 0 alone is then granted next.
- Source 2, len=4. Hold gf_full=1 for 5 cycles after the 2nd output beat → beat 2 is held stable, src_ready[2]=0 during the stall. Beats 3 and 4 follow once full drops. Exactly 4 beats with data matching in order.
- src_len=0 on source 1 → 4096 beats, eop only on beat 4096, gf_len=0 on every beat.
- Assert resetN=0 mid-message (beat 2 of 5) → all outputs 0 asynchronously. After release, no stale beats. A fresh len=2 request completes normally with msg_count=1.
- Sources 0 and 3 valid, source 0 drops src_valid for 3 cycles mid-message → 3 bubbles appear in gf_req. Source 3 is not granted until source 0's eop beat is accepted.

Source files
------------

// File: rtl/gfifo_src_arb.sv
// Round-robin message arbiter feeding the output GFIFO: grants whole messages from
// NUM_SRC sources and streams their beats through one registered output stage.
module gfifo_src_arb #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 512,
  parameter int CBW     = 20,
  parameter int LW      = 12
) (
  input  logic                   fclk,
  input  logic                   resetN,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic [NUM_SRC*CBW-1:0] src_cbid,
  input  logic [NUM_SRC*LW-1:0]  src_len,
  input  logic [NUM_SRC*DW-1:0]  src_data,
  output logic                   gf_req,
  output logic                   gf_sop,
  output logic                   gf_eop,
  output logic [CBW-1:0]         gf_cbid,
  output logic [LW-1:0]          gf_len,
  output logic [DW-1:0]          gf_idata,
  input  logic                   gf_full,
  output logic                   gf_busy,
  output logic [31:0]            msg_count
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d, gnt_q, gnt_d, arb_idx;
  logic            arb_hit;
  logic [CBW-1:0]  cbid_q, cbid_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW:0]     rem_q, rem_d;
  logic            first_q, first_d;
  logic            req_q, req_d, sop_q, sop_d, eop_q, eop_d;
  logic [CBW-1:0]  ocbid_q, ocbid_d;
  logic [LW-1:0]   olen_q, olen_d;
  logic [DW-1:0]   odata_q, odata_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            load, accept;

  logic [CBW-1:0]  cbid_a [NUM_SRC];
  logic [LW-1:0]   len_a  [NUM_SRC];
  logic [DW-1:0]   data_a [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign cbid_a[gi]    = src_cbid[gi*CBW +: CBW];
      assign len_a[gi]     = src_len[gi*LW +: LW];
      assign data_a[gi]    = src_data[gi*DW +: DW];
      assign src_ready[gi] = (state_q == XFER) && load && (gnt_q == PW'(gi));
    end
  endgenerate

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    logic [PW:0] sum;
    arb_hit = 1'b0;
    arb_idx = '0;
    sum     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, rr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_SRC)) sum = sum - (PW+1)'(NUM_SRC);
      if (!arb_hit && src_valid[sum[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cbid_d  = cbid_q;
    len_d   = len_q;
    rem_d   = rem_q;
    first_d = first_q;
    req_d   = req_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    ocbid_d = ocbid_q;
    olen_d  = olen_q;
    odata_d = odata_q;
    cnt_d   = cnt_q;
    load    = !req_q || !gf_full;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          gnt_d   = arb_idx;
          cbid_d  = cbid_a[arb_idx];
          len_d   = len_a[arb_idx];
          rem_d   = (len_a[arb_idx] == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, len_a[arb_idx]};
          first_d = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        accept = load && src_valid[gnt_q];
        if (accept) begin
          rem_d   = rem_q - 1'b1;
          first_d = 1'b0;
          if (rem_q == (LW+1)'(1)) begin
            state_d = IDLE;
            rr_d    = (gnt_q == PW'(NUM_SRC-1)) ? '0 : gnt_q + 1'b1;
          end
        end
      end
    endcase

    // A stalled beat holds every output; otherwise load a new beat or a bubble.
    if (load) begin
      req_d = accept;
      sop_d = 1'b0;
      eop_d = 1'b0;
      if (accept) begin
        sop_d   = first_q;
        eop_d   = (rem_q == (LW+1)'(1));
        ocbid_d = cbid_q;
        olen_d  = len_q;
        odata_d = data_a[gnt_q];
      end
    end

    if (req_q && eop_q && !gf_full) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge fclk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cbid_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      req_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      ocbid_q <= '0;
      olen_q  <= '0;
      odata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cbid_q  <= cbid_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      req_q   <= req_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      ocbid_q <= ocbid_d;
      olen_q  <= olen_d;
      odata_q <= odata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gf_req    = req_q;
  assign gf_sop    = sop_q;
  assign gf_eop    = eop_q;
  assign gf_cbid   = ocbid_q;
  assign gf_len    = olen_q;
  assign gf_idata  = odata_q;
  assign gf_busy   = (state_q == XFER) || req_q;
  assign msg_count = cnt_q;

endmodule
